pipe_issue_ctrl: RTL and testbench
==================================

// Module: pipe_issue_ctrl
// PURPOSE
//  Central issue/hazard controller for the DPU. Holds a register scoreboard and an in-flight counter,
//  and grants issue of the decoded instruction. Sequences branch redirects (PFU flush + new PC) and
//  trap entry (drain, then handshake). Sits between the DPU decode stage and the PFU.
// PARAMETERS
//  RF_ADDR_WIDTH  5   register-file address width; the scoreboard has 2**RF_ADDR_WIDTH bits
//  PC_WIDTH       32  program-counter width
//  MAX_INFLIGHT   4   maximum number of issued-but-not-retired instructions (1..15)
// PORTS
//  clk_i            in   1              clock
//  rst_i            in   1              asynchronous reset, active-high
//  dec_valid_i      in   1              DPU holds a decoded instruction
//  dec_rs1_used_i   in   1              instruction reads rs1
//  dec_rs1_addr_i   in   RF_ADDR_WIDTH  rs1 address
//  dec_rs2_used_i   in   1              instruction reads rs2
//  dec_rs2_addr_i   in   RF_ADDR_WIDTH  rs2 address
//  dec_rd_used_i    in   1              instruction writes rd
//  dec_rd_addr_i    in   RF_ADDR_WIDTH  rd address
//  dec_is_trap_i    in   1              instruction is ecall, ebreak or mret
//  br_valid_i       in   1              execute resolved a taken branch/jump (one-cycle pulse)
//  br_pc_i          in   PC_WIDTH       branch target
//  wb_valid_i       in   1              an instruction retires this cycle
//  wb_rd_used_i     in   1              the retiring instruction wrote rd
//  wb_rd_addr_i     in   RF_ADDR_WIDTH  rd of the retiring instruction
//  trap_ack_i       in   1              trap unit accepted the request
//  issue_o          out  1              decoded instruction issues this cycle (combinational)
//  stall_o          out  1              DPU must hold its instruction (= dec_valid_i & ~issue_o)
//  flush_o          out  1              flush PFU/DPU (registered)
//  redirect_valid_o out  1              PFU must restart fetch at redirect_pc_o (registered)
//  redirect_pc_o    out  PC_WIDTH       restart PC
//  trap_req_o       out  1              request trap entry; held until trap_ack_i
// BEHAVIOUR
//  Reset values: all outputs 0, scoreboard 0, inflight 0, state RUN.
//  Hazard: RAW is (rsN_used & rsN!=0 & sb[rsN]); WAW is (rd_used & rd!=0 & sb[rd]).
//   Checks use registered scoreboard only; no same-cycle bypass from wb.
//  Issue: issue_o = state==RUN & dec_valid_i & ~hazard & inflight<MAX_INFLIGHT & ~br_valid_i & ~dec_is_trap_i.
//  On issue: set sb[rd] if rd_used & rd!=0; inflight+1.
//  On wb_valid_i: clear sb[wb_rd] if wb_rd_used_i; inflight-1.
//   Issue and wb in the same cycle leave inflight unchanged.
//   WAW stall prevents a same-register set/clear collision.
//  wb_valid_i with inflight==0 is a protocol error: the counter saturates at 0.
//  x0 is never marked pending.
//  FSM:
//   RUN: br_valid_i -> REDIR and latch br_pc_i (branch beats trap and issue in the same cycle).
//        Else dec_valid_i & dec_is_trap_i -> DRAIN.
//   REDIR: flush_o=1 and redirect_valid_o=1 for exactly one cycle; scoreboard untouched, since
//        older in-flight ops still retire. -> RUN.
//   DRAIN: no issue; wait for inflight==0 and sb==0; br_valid_i here -> REDIR (trap discarded).
//        Drain complete -> TRAPW.
//   TRAPW: trap_req_o=1 until trap_ack_i -> REDIR, with flush and redirect_pc_o unchanged;
//        the trap unit supplies the PC via br_valid_i.
//  br_valid_i during REDIR or TRAPW is ignored; br_valid_i during DRAIN is handled as above.
//  Reset mid-operation: immediate return to reset values; pending ops are lost.
// CONFIGURATION
//  PIPE_ISSUE_CTRL_PERF_EN defined: adds outputs perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0].
//   Stall counter increments on each stall_o cycle; flush counter on each flush_o cycle.
//   Both wrap at 2**32 and reset to 0.
//  PIPE_ISSUE_CTRL_PERF_EN undefined: the ports and counters do not exist.
// TESTING
//  1. Issue rd=5, then rs1=5 before wb -> stall_o=1 until wb_rd=5; issue_o in the cycle after wb.
//  2. Issue 4 independent ops with no wb -> 5th stalls (MAX_INFLIGHT=4); one wb -> 5th issues next cycle.
//  3. br_valid_i=1, br_pc_i=0x0000_0100 -> next cycle flush_o=1, redirect_pc_o=0x100 for 1 cycle.
//  4. ecall with 2 ops in flight -> trap_req_o rises 1 cycle after 2nd wb.
//     trap_ack_i -> flush_o pulse, then RUN.
//  5. br_valid_i together with ecall decode -> REDIR only; trap_req_o never asserted.
//  6. Ops writing x0 -> sb stays 0; rst_i mid-DRAIN -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/pipe_issue_ctrl.sv
// Issue/hazard controller: register scoreboard, in-flight limit, redirect and trap sequencing.
// Optional perf counters when PIPE_ISSUE_CTRL_PERF_EN is defined.
module pipe_issue_ctrl #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int PC_WIDTH      = 32,
  parameter int MAX_INFLIGHT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dec_valid_i,
  input  logic                     dec_rs1_used_i,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rs1_addr_i,
  input  logic                     dec_rs2_used_i,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rs2_addr_i,
  input  logic                     dec_rd_used_i,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rd_addr_i,
  input  logic                     dec_is_trap_i,
  input  logic                     br_valid_i,
  input  logic [PC_WIDTH-1:0]      br_pc_i,
  input  logic                     wb_valid_i,
  input  logic                     wb_rd_used_i,
  input  logic [RF_ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic                     trap_ack_i,
  output logic                     issue_o,
  output logic                     stall_o,
  output logic                     flush_o,
  output logic                     redirect_valid_o,
  output logic [PC_WIDTH-1:0]      redirect_pc_o,
  output logic                     trap_req_o
`ifdef PIPE_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt_o,
  output logic [31:0]              perf_flush_cnt_o
`endif
);

  localparam int NREG = 1 << RF_ADDR_WIDTH;
  localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_RUN,
    S_REDIR,
    S_DRAIN,
    S_TRAPW
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NREG-1:0]     r_sb;
  logic [NREG-1:0]     w_sb_nxt;
  logic [NREG-1:0]     w_sb_set;
  logic [NREG-1:0]     w_sb_clr;
  logic [3:0]          r_inflight;
  logic [3:0]          w_inflight_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;

  logic w_raw1;
  logic w_raw2;
  logic w_waw;
  logic w_hazard;
  logic w_full;
  logic w_issue;
  logic w_retire;
  logic w_drained;

  assign w_raw1 = dec_rs1_used_i & (dec_rs1_addr_i != '0)
                & r_sb[dec_rs1_addr_i];
  assign w_raw2 = dec_rs2_used_i & (dec_rs2_addr_i != '0)
                & r_sb[dec_rs2_addr_i];
  assign w_waw  = dec_rd_used_i & (dec_rd_addr_i != '0)
                & r_sb[dec_rd_addr_i];
  assign w_hazard = w_raw1 | w_raw2 | w_waw;
  assign w_full   = (r_inflight >= MAX_IF);

  // Reset gating keeps every output low while rst_i is held.
  assign w_issue = (r_state == S_RUN) & dec_valid_i & ~w_hazard
                 & ~w_full & ~br_valid_i & ~dec_is_trap_i & ~rst_i;

  // A retire with nothing in flight is ignored so the counter floors at 0.
  assign w_retire  = wb_valid_i & (r_inflight != '0);
  assign w_drained = (r_inflight == '0) & (r_sb == '0);

  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (w_issue && dec_rd_used_i && (dec_rd_addr_i != '0))
      w_sb_set[dec_rd_addr_i] = 1'b1;
    if (wb_valid_i && wb_rd_used_i)
      w_sb_clr[wb_rd_addr_i] = 1'b1;
    w_sb_nxt = (r_sb & ~w_sb_clr) | w_sb_set;
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    unique case ({w_issue, w_retire})
      2'b10:   w_inflight_nxt = r_inflight + 4'd1;
      2'b01:   w_inflight_nxt = r_inflight - 4'd1;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_RUN: begin
        if (br_valid_i) begin
          w_state_nxt = S_REDIR;
          w_pc_nxt    = br_pc_i;
        end else if (dec_valid_i && dec_is_trap_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_REDIR: w_state_nxt = S_RUN;
      S_DRAIN: begin
        if (br_valid_i) begin
          w_state_nxt = S_REDIR;
          w_pc_nxt    = br_pc_i;
        end else if (w_drained) begin
          w_state_nxt = S_TRAPW;
        end
      end
      S_TRAPW: begin
        // Trap handoff reuses the last redirect PC; the trap unit steers fetch later.
        if (trap_ack_i)
          w_state_nxt = S_REDIR;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_RUN;
      r_sb       <= '0;
      r_inflight <= '0;
      r_pc       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sb       <= w_sb_nxt;
      r_inflight <= w_inflight_nxt;
      r_pc       <= w_pc_nxt;
    end
  end

  assign issue_o          = w_issue;
  assign stall_o          = dec_valid_i & ~w_issue & ~rst_i;
  assign flush_o          = (r_state == S_REDIR);
  assign redirect_valid_o = (r_state == S_REDIR);
  assign redirect_pc_o    = r_pc;
  assign trap_req_o       = (r_state == S_TRAPW);

`ifdef PIPE_ISSUE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(stall_o);
      r_flush_cnt <= r_flush_cnt + 32'(flush_o);
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
  assign perf_flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed scenarios plus randomized
// issue/retire/branch traffic against a queue-based reference model.
module tb_pipe_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dec_valid_i;
  logic        dec_rs1_used_i;
  logic [4:0]  dec_rs1_addr_i;
  logic        dec_rs2_used_i;
  logic [4:0]  dec_rs2_addr_i;
  logic        dec_rd_used_i;
  logic [4:0]  dec_rd_addr_i;
  logic        dec_is_trap_i;
  logic        br_valid_i;
  logic [31:0] br_pc_i;
  logic        wb_valid_i;
  logic        wb_rd_used_i;
  logic [4:0]  wb_rd_addr_i;
  logic        trap_ack_i;
  logic        issue_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        trap_req_o;
`ifdef PIPE_ISSUE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_flush_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  int mq[$];

  pipe_issue_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .dec_valid_i      (dec_valid_i),
    .dec_rs1_used_i   (dec_rs1_used_i),
    .dec_rs1_addr_i   (dec_rs1_addr_i),
    .dec_rs2_used_i   (dec_rs2_used_i),
    .dec_rs2_addr_i   (dec_rs2_addr_i),
    .dec_rd_used_i    (dec_rd_used_i),
    .dec_rd_addr_i    (dec_rd_addr_i),
    .dec_is_trap_i    (dec_is_trap_i),
    .br_valid_i       (br_valid_i),
    .br_pc_i          (br_pc_i),
    .wb_valid_i       (wb_valid_i),
    .wb_rd_used_i     (wb_rd_used_i),
    .wb_rd_addr_i     (wb_rd_addr_i),
    .trap_ack_i       (trap_ack_i),
    .issue_o          (issue_o),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .trap_req_o       (trap_req_o)
`ifdef PIPE_ISSUE_CTRL_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    dec_valid_i    = 0;
    dec_rs1_used_i = 0;
    dec_rs1_addr_i = 0;
    dec_rs2_used_i = 0;
    dec_rs2_addr_i = 0;
    dec_rd_used_i  = 0;
    dec_rd_addr_i  = 0;
    dec_is_trap_i  = 0;
    br_valid_i     = 0;
    br_pc_i        = 0;
    wb_valid_i     = 0;
    wb_rd_used_i   = 0;
    wb_rd_addr_i   = 0;
    trap_ack_i     = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic op_rd(input logic [4:0] rd);
    dec_valid_i   = 1;
    dec_rd_used_i = 1;
    dec_rd_addr_i = rd;
  endtask

  task automatic retire(input logic used, input logic [4:0] rd);
    wb_valid_i   = 1;
    wb_rd_used_i = used;
    wb_rd_addr_i = rd;
    step();
    wb_valid_i   = 0;
  endtask

  function automatic bit pend(input int r);
    foreach (mq[i]) if (mq[i] == r) return 1;
    return 0;
  endfunction

  task automatic test_reset();
    rst_i = 1;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({issue_o, stall_o, flush_o, redirect_valid_o, trap_req_o,
         redirect_pc_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got issue=%b stall=%b flush=%b rv=%b trap=%b pc=%h want all 0",
               issue_o, stall_o, flush_o, redirect_valid_o, trap_req_o, redirect_pc_o);
    end
    rst_i = 0;
    #1;
  endtask

  task automatic test_raw();
    idle();
    op_rd(5);
    #1;
    total++;
    if (issue_o !== 1) begin bad++; $display("FAIL raw_first_issue got %b want 1", issue_o); end
    step();
    dec_rd_used_i  = 0;
    dec_rs1_used_i = 1;
    dec_rs1_addr_i = 5;
    #1;
    total++;
    if (stall_o !== 1 || issue_o !== 0) begin
      bad++; $display("FAIL raw_stall got stall=%b issue=%b want 1/0", stall_o, issue_o);
    end
    step();
    wb_valid_i = 1; wb_rd_used_i = 1; wb_rd_addr_i = 5;
    #1;
    total++;
    if (stall_o !== 1) begin bad++; $display("FAIL raw_no_bypass got stall=%b want 1", stall_o); end
    step();
    wb_valid_i = 0;
    #1;
    total++;
    if (issue_o !== 1) begin bad++; $display("FAIL raw_after_wb got issue=%b want 1", issue_o); end
    step();
    idle();
    retire(0, 0);
  endtask

  task automatic test_inflight();
    idle();
    for (int i = 0; i < 4; i++) begin
      op_rd(5'(i + 1));
      #1;
      total++;
      if (issue_o !== 1) begin bad++; $display("FAIL inflight_fill%0d got issue=%b want 1", i, issue_o); end
      step();
    end
    op_rd(10);
    #1;
    total++;
    if (stall_o !== 1 || issue_o !== 0) begin
      bad++; $display("FAIL inflight_full got stall=%b issue=%b want 1/0", stall_o, issue_o);
    end
    wb_valid_i = 1; wb_rd_used_i = 1; wb_rd_addr_i = 1;
    #1;
    total++;
    if (stall_o !== 1) begin bad++; $display("FAIL inflight_wb_cycle got stall=%b want 1", stall_o); end
    step();
    wb_valid_i = 0;
    #1;
    total++;
    if (issue_o !== 1) begin bad++; $display("FAIL inflight_after_wb got issue=%b want 1", issue_o); end
    step();
    idle();
    retire(1, 2); retire(1, 3); retire(1, 4); retire(1, 10);
  endtask

  task automatic test_branch();
    idle();
    dec_valid_i = 1;
    br_valid_i  = 1;
    br_pc_i     = 32'h0000_0100;
    #1;
    total++;
    if (issue_o !== 0 || stall_o !== 1) begin
      bad++; $display("FAIL br_blocks_issue got issue=%b stall=%b want 0/1", issue_o, stall_o);
    end
    step();
    br_valid_i = 0;
    #1;
    total++;
    if (flush_o !== 1 || redirect_valid_o !== 1 || redirect_pc_o !== 32'h100 || issue_o !== 0) begin
      bad++; $display("FAIL br_redirect got flush=%b rv=%b pc=%h issue=%b want 1/1/100/0",
                      flush_o, redirect_valid_o, redirect_pc_o, issue_o);
    end
    step();
    #1;
    total++;
    if (flush_o !== 0 || redirect_valid_o !== 0 || issue_o !== 1) begin
      bad++; $display("FAIL br_one_cycle got flush=%b rv=%b issue=%b want 0/0/1",
                      flush_o, redirect_valid_o, issue_o);
    end
    dec_valid_i = 0;
    #1;
  endtask

  task automatic test_trap();
    idle();
    op_rd(1); step();
    op_rd(2); step();
    idle();
    dec_valid_i = 1; dec_is_trap_i = 1;
    #1;
    total++;
    if (issue_o !== 0 || stall_o !== 1) begin
      bad++; $display("FAIL trap_no_issue got issue=%b stall=%b want 0/1", issue_o, stall_o);
    end
    step();
    retire(1, 1);
    wb_valid_i = 1; wb_rd_used_i = 1; wb_rd_addr_i = 2;
    #1;
    total++;
    if (trap_req_o !== 0) begin bad++; $display("FAIL trap_early_wb got trap=%b want 0", trap_req_o); end
    step();
    wb_valid_i = 0;
    #1;
    total++;
    if (trap_req_o !== 0) begin bad++; $display("FAIL trap_drain_eval got trap=%b want 0", trap_req_o); end
    step();
    total++;
    if (trap_req_o !== 1) begin bad++; $display("FAIL trap_req_rise got trap=%b want 1", trap_req_o); end
    br_valid_i = 1; br_pc_i = 32'h200;
    step();
    br_valid_i = 0;
    #1;
    total++;
    if (trap_req_o !== 1 || flush_o !== 0) begin
      bad++; $display("FAIL trapw_ignores_br got trap=%b flush=%b want 1/0", trap_req_o, flush_o);
    end
    trap_ack_i = 1;
    step();
    trap_ack_i = 0;
    dec_valid_i = 0; dec_is_trap_i = 0;
    #1;
    total++;
    if (flush_o !== 1 || redirect_valid_o !== 1 || redirect_pc_o !== 32'h100 || trap_req_o !== 0) begin
      bad++; $display("FAIL trap_ack_flush got flush=%b rv=%b pc=%h trap=%b want 1/1/100/0",
                      flush_o, redirect_valid_o, redirect_pc_o, trap_req_o);
    end
    step();
    dec_valid_i = 1;
    #1;
    total++;
    if (flush_o !== 0 || issue_o !== 1) begin
      bad++; $display("FAIL trap_back_run got flush=%b issue=%b want 0/1", flush_o, issue_o);
    end
    dec_valid_i = 0;
    #1;
  endtask

  task automatic test_br_trap();
    idle();
    dec_valid_i = 1; dec_is_trap_i = 1;
    br_valid_i = 1; br_pc_i = 32'h300;
    step();
    idle();
    #1;
    total++;
    if (flush_o !== 1 || redirect_pc_o !== 32'h300 || trap_req_o !== 0) begin
      bad++; $display("FAIL br_trap_redir got flush=%b pc=%h trap=%b want 1/300/0",
                      flush_o, redirect_pc_o, trap_req_o);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (trap_req_o !== 0 || flush_o !== 0) begin
        bad++; $display("FAIL br_trap_quiet%0d got trap=%b flush=%b want 0/0", i, trap_req_o, flush_o);
      end
    end
  endtask

  task automatic test_drain_branch();
    idle();
    op_rd(7); step();
    idle();
    dec_valid_i = 1; dec_is_trap_i = 1;
    step();
    step();
    br_valid_i = 1; br_pc_i = 32'h400;
    step();
    idle();
    #1;
    total++;
    if (flush_o !== 1 || redirect_pc_o !== 32'h400 || trap_req_o !== 0) begin
      bad++; $display("FAIL drain_br got flush=%b pc=%h trap=%b want 1/400/0",
                      flush_o, redirect_pc_o, trap_req_o);
    end
    step();
    retire(1, 7);
    repeat (2) step();
    total++;
    if (trap_req_o !== 0 || flush_o !== 0) begin
      bad++; $display("FAIL drain_br_discard got trap=%b flush=%b want 0/0", trap_req_o, flush_o);
    end
  endtask

  task automatic test_x0();
    idle();
    op_rd(0);
    step();
    dec_rs1_used_i = 1; dec_rs2_used_i = 1;
    #1;
    total++;
    if (issue_o !== 1) begin bad++; $display("FAIL x0_never_pending got issue=%b want 1", issue_o); end
    step();
    idle();
    retire(1, 0); retire(1, 0);
  endtask

  task automatic test_reset_mid_drain();
    idle();
    op_rd(9); step();
    idle();
    dec_valid_i = 1; dec_is_trap_i = 1;
    step();
    step();
    rst_i = 1;
    #1;
    total++;
    if ({issue_o, stall_o, flush_o, redirect_valid_o, trap_req_o,
         redirect_pc_o} !== '0) begin
      bad++;
      $display("FAIL reset_mid_drain got issue=%b stall=%b flush=%b rv=%b trap=%b pc=%h want all 0",
               issue_o, stall_o, flush_o, redirect_valid_o, trap_req_o, redirect_pc_o);
    end
    step();
    rst_i = 0;
    idle();
    dec_valid_i = 1; dec_rs1_used_i = 1; dec_rs1_addr_i = 9;
    #1;
    total++;
    if (issue_o !== 1) begin bad++; $display("FAIL reset_clears_sb got issue=%b want 1", issue_o); end
    step();
    idle();
    retire(0, 0);
  endtask

  task automatic test_random();
    bit          redir = 0;
    bit          exp_issue;
    bit          haz;
    logic [31:0] last_pc = 32'h400;
    mq.delete();
    for (int n = 0; n < 600; n++) begin
      idle();
      dec_valid_i    = ($urandom_range(0, 3) != 0);
      dec_rs1_used_i = 1'($urandom);
      dec_rs1_addr_i = 5'($urandom_range(0, 3));
      dec_rs2_used_i = 1'($urandom);
      dec_rs2_addr_i = 5'($urandom_range(0, 3));
      dec_rd_used_i  = 1'($urandom);
      dec_rd_addr_i  = 5'($urandom_range(0, 3));
      br_valid_i     = ($urandom_range(0, 11) == 0);
      br_pc_i        = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        wb_valid_i   = 1;
        wb_rd_used_i = (mq[0] >= 0);
        wb_rd_addr_i = (mq[0] >= 0) ? 5'(mq[0]) : 5'($urandom);
      end
      #1;
      haz = (dec_rs1_used_i && dec_rs1_addr_i != 0 && pend(int'(dec_rs1_addr_i)))
         || (dec_rs2_used_i && dec_rs2_addr_i != 0 && pend(int'(dec_rs2_addr_i)))
         || (dec_rd_used_i  && dec_rd_addr_i  != 0 && pend(int'(dec_rd_addr_i)));
      exp_issue = !redir && dec_valid_i && !haz && mq.size() < 4 && !br_valid_i;
      total++;
      if (issue_o !== exp_issue || stall_o !== (dec_valid_i && !exp_issue)
          || flush_o !== redir || redirect_valid_o !== redir || trap_req_o !== 0
          || (redir && redirect_pc_o !== last_pc)) begin
        bad++;
        $display("FAIL rand%0d got issue=%b stall=%b flush=%b rv=%b pc=%h trap=%b want %b/%b/%b/%b/%h/0",
                 n, issue_o, stall_o, flush_o, redirect_valid_o, redirect_pc_o, trap_req_o,
                 exp_issue, dec_valid_i && !exp_issue, redir, redir, last_pc);
      end
      step();
      if (wb_valid_i) void'(mq.pop_front());
      if (exp_issue) mq.push_back(dec_rd_used_i ? int'(dec_rd_addr_i) : -1);
      if (!redir && br_valid_i) begin
        redir   = 1;
        last_pc = br_pc_i;
      end else begin
        redir = 0;
      end
    end
    idle();
    step();
    while (mq.size() > 0) begin
      retire(mq[0] >= 0, (mq[0] >= 0) ? 5'(mq[0]) : 5'd0);
      void'(mq.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_inflight();
    test_branch();
    test_trap();
    test_br_trap();
    test_drain_branch();
    test_x0();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
